inst_line_fill: RTL

Line-fill controller sitting directly upstream of the instruction RAM's 128-bit line-write port. On a fill request it fetches the four 32-bit words of one instruction line from the external memory bus, assembles them into a 128-bit line, and writes the line into the instruction RAM in a single cycle. It drives the RAM write port (`ram_wadr_all`, `ram_wdata_all`, `ram_wen_all`) and reports completion to the fetch/miss logic.

---
 rtl/inst_line_fill.sv | 98 +++++++++
 1 files changed

// File: rtl/inst_line_fill.sv
// inst_line_fill: fetches the four 32-bit beats of one instruction line from the memory bus,
// assembles them, and writes the whole 128-bit line into the instruction RAM in one cycle.
module inst_line_fill #(
  parameter int IWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_req,
  input  logic [IWIDTH-3:0] fill_ladr,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_rreq,
  output logic [IWIDTH-1:0] mem_radr,
  input  logic              mem_rgnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [IWIDTH-3:0] ram_wadr_all,
  output logic [127:0]      ram_wdata_all,
  output logic              ram_wen_all
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
  state_t            state_q, state_d;
  logic [IWIDTH-3:0] line_q, line_d, wadr_q, wadr_d;
  logic [2:0]        req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [127:0]      asm_q, asm_d, wdata_q, wdata_d;
  logic              rreq_q, rreq_d, busy_q, busy_d, wen_q, wen_d;
  logic              gnt, rv;
  assign gnt = rreq_q & mem_rgnt;
  // rvalids outside FETCH belong to an aborted fill or are spurious and are dropped
  assign rv  = (state_q == FETCH) && mem_rvalid && !rsp_cnt_q[2];
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    asm_d     = asm_q;
    wadr_d    = wadr_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    case (state_q)
      IDLE: if (fill_req) begin
        state_d   = FETCH;
        line_d    = fill_ladr;
        req_cnt_d = 3'd0;
        rsp_cnt_d = 3'd0;
      end
      FETCH: begin
        req_cnt_d = req_cnt_q + 3'(gnt);
        if (rv) begin
          asm_d[{rsp_cnt_q[1:0], 5'b0} +: 32] = mem_rdata;
          rsp_cnt_d = rsp_cnt_q + 3'd1;
        end
        // the write is launched on the edge of the 4th beat so the line includes it
        if (rsp_cnt_d[2]) begin
          state_d = WRITE;
          wen_d   = 1'b1;
          wadr_d  = line_q;
          wdata_d = asm_d;
        end
      end
      default: state_d = IDLE;
    endcase
    rreq_d = (state_d == FETCH) && !req_cnt_d[2];
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      asm_q     <= '0;
      wadr_q    <= '0;
      wdata_q   <= '0;
      rreq_q    <= 1'b0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      asm_q     <= asm_d;
      wadr_q    <= wadr_d;
      wdata_q   <= wdata_d;
      rreq_q    <= rreq_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
    end
  end
  assign mem_rreq      = rreq_q;
  assign mem_radr      = {line_q, req_cnt_q[1:0]};
  assign fill_busy     = busy_q;
  assign fill_done     = wen_q;
  assign ram_wen_all   = wen_q;
  assign ram_wadr_all  = wadr_q;
  assign ram_wdata_all = wdata_q;
endmodule
